// File: rtl/bnn_layer_scheduler.sv
// Sequences one fully-connected BNN layer over a bank of NP lanes: stream chunks per group, collect lane bits, emit one result word.
// Three cycles per chunk (issue/data/guard) plus NP time. The result is held on res_valid until res_ready, and no reads are issued meanwhile.
module bnn_layer_scheduler #(
  parameter int PARALLEL_INPUTS  = 1,
  parameter int PARALLEL_NEURONS = 1,
  parameter int NUM_INPUTS       = 2,
  parameter int NUM_NEURONS      = 2,
  parameter int ADDR_W           = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_rd_en,
  output logic [ADDR_W-1:0]           w_addr,
  output logic [ADDR_W-1:0]           in_addr,
  output logic [ADDR_W-1:0]           thr_addr,
  input  logic [PARALLEL_NEURONS-1:0] np_rd_en,
  output logic                        np_data_valid,
  input  logic [PARALLEL_NEURONS-1:0] np_out_valid,
  input  logic [PARALLEL_NEURONS-1:0] np_out,
  output logic [PARALLEL_NEURONS-1:0] res_data,
  output logic [ADDR_W-1:0]           res_group,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        err_dup
);

  localparam int P_N     = PARALLEL_NEURONS;
  localparam int CHUNKS  = (NUM_INPUTS + PARALLEL_INPUTS - 1) / PARALLEL_INPUTS;
  localparam int GROUPS  = (NUM_NEURONS + P_N - 1) / P_N;
  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int GROUP_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
  localparam logic [GROUP_W-1:0] LAST_GROUP = GROUP_W'(GROUPS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_GUARD   = 3'd3;
  localparam logic [2:0] S_COLLECT = 3'd4;
  localparam logic [2:0] S_EMIT    = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [GROUP_W-1:0] group_q, group_d;
  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic [P_N-1:0]     seen_q, seen_d;
  logic [P_N-1:0]     res_q, res_d;
  logic [P_N-1:0]     rdy_q;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic [P_N-1:0]     active;
  logic               all_rdy;

  // Only lanes of the final, partially filled group can be inactive.
  always_comb begin
    active = '0;
    for (int i = 0; i < P_N; i++) begin
      active[i] = ((int'(group_q) * P_N + i) < NUM_NEURONS);
    end
  end

  // NP readiness is registered so mem_rd_en depends on state only; the guard cycle hides the extra delay.
  assign all_rdy = &(rdy_q | ~active);

  always_comb begin
    state_d = state_q;
    group_d = group_q;
    chunk_d = chunk_q;
    seen_d  = seen_q;
    res_d   = res_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          group_d = '0;
          chunk_d = '0;
          seen_d  = '0;
          res_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        if (all_rdy) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        state_d = S_GUARD;
      end
      S_GUARD: begin
        if (chunk_q == LAST_CHUNK) begin
          state_d = S_COLLECT;
        end else begin
          chunk_d = chunk_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_COLLECT: begin
        // Inactive lanes count as already seen, so a strobe on one is a duplicate.
        for (int i = 0; i < P_N; i++) begin
          if (np_out_valid[i]) begin
            if (seen_q[i] || !active[i]) begin
              err_d = 1'b1;
            end else begin
              seen_d[i] = 1'b1;
              res_d[i]  = np_out[i];
            end
          end
        end
        if (&(seen_d | ~active)) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          seen_d  = '0;
          res_d   = '0;
          chunk_d = '0;
          if (group_q == LAST_GROUP) begin
            state_d = S_IDLE;
            group_d = '0;
            done_d  = 1'b1;
          end else begin
            group_d = group_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      group_q <= '0;
      chunk_q <= '0;
      seen_q  <= '0;
      res_q   <= '0;
      rdy_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      group_q <= group_d;
      chunk_q <= chunk_d;
      seen_q  <= seen_d;
      res_q   <= res_d;
      rdy_q   <= np_rd_en;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign mem_rd_en     = (state_q == S_ISSUE) && all_rdy;
  assign np_data_valid = (state_q == S_DATA);
  assign res_valid     = (state_q == S_EMIT);
  assign res_data      = res_q;
  assign res_group     = ADDR_W'(group_q);
  assign err_dup       = err_q;

  assign w_addr   = ADDR_W'(group_q) * ADDR_W'(CHUNKS) + ADDR_W'(chunk_q);
  assign in_addr  = ADDR_W'(chunk_q);
  assign thr_addr = ADDR_W'(group_q);

endmodule

// File: tb/tb_bnn_layer_scheduler.sv
// Self-checking bench for bnn_layer_scheduler: table rows, hand sequences and random layers against a behavioural model.
module tb_bnn_layer_scheduler;

  localparam int P_I    = 4;
  localparam int P_N    = 2;
  localparam int N_IN   = 8;
  localparam int N_NEU  = 3;
  localparam int AW     = 16;
  localparam int CHUNKS = (N_IN + P_I - 1) / P_I;
  localparam int GROUPS = (N_NEU + P_N - 1) / P_N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] in_addr;
  logic [AW-1:0] thr_addr;
  logic [P_N-1:0] np_rd_en;
  logic          np_data_valid;
  logic [P_N-1:0] np_out_valid;
  logic [P_N-1:0] np_out;
  logic [P_N-1:0] res_data;
  logic [AW-1:0] res_group;
  logic          res_valid;
  logic          res_ready;
  logic          err_dup;

  always #5 clk = ~clk;

  bnn_layer_scheduler #(
    .PARALLEL_INPUTS(P_I),
    .PARALLEL_NEURONS(P_N),
    .NUM_INPUTS(N_IN),
    .NUM_NEURONS(N_NEU),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .mem_rd_en(mem_rd_en),
    .w_addr(w_addr),
    .in_addr(in_addr),
    .thr_addr(thr_addr),
    .np_rd_en(np_rd_en),
    .np_data_valid(np_data_valid),
    .np_out_valid(np_out_valid),
    .np_out(np_out),
    .res_data(res_data),
    .res_group(res_group),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .err_dup(err_dup)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: every memory read and every done pulse, observed mid-cycle.
  logic [47:0] addr_log[$];
  int          done_cnt = 0;
  always @(negedge clk) begin
    if (mem_rd_en) addr_log.push_back({w_addr, in_addr, thr_addr});
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Neuron g*P_N+i exists only if it is below the layer size; missing neurons read as 0.
  function automatic logic [P_N-1:0] model_res(input int g, input logic [P_N-1:0] bits);
    logic [P_N-1:0] r;
    for (int i = 0; i < P_N; i++) r[i] = (g * P_N + i < N_NEU) ? bits[i] : 1'b0;
    return r;
  endfunction

  task automatic strobe(input logic [1:0] m, input logic [1:0] b);
    np_out_valid = m;
    np_out       = b;
    @(negedge clk);
    np_out_valid = '0;
    np_out       = 2'($urandom);
  endtask

  // Acts as the NP bank for one group, then checks and accepts the result word.
  task automatic do_group(input int g, input logic [1:0] bits, input bit dup, input bit stray,
                          input int hold, input bit drop_rdy, input logic [1:0] exp);
    logic [1:0]  act_m;
    logic [1:0]  d0;
    logic [15:0] grp0;
    bit          stable;
    bit          no_rd;
    int          n;
    int          k;
    act_m = model_res(g, 2'b11);
    if (stray) begin
      np_out_valid = 2'b11;
      np_out       = ~bits;
    end
    n = 0;
    k = 0;
    while (n < CHUNKS && k < 200) begin
      @(negedge clk);
      np_out_valid = '0;
      k++;
      if (np_data_valid) n++;
    end
    chk($sformatf("g%0d_data_pulses", g), 64'(n), 64'(CHUNKS));
    @(negedge clk);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    if (dup) begin
      strobe(2'b10, bits);
      strobe(2'b10, ~bits);
      strobe(2'b01, bits);
    end else begin
      case ($urandom_range(0, 2))
        0: strobe(act_m, bits);
        1: begin
          strobe(2'b01, bits);
          if (act_m[1]) strobe(2'b10, bits);
        end
        default: begin
          if (act_m[1]) strobe(2'b10, bits);
          strobe(2'b01, bits);
        end
      endcase
    end
    k = 0;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("g%0d_res_valid", g), 64'(res_valid), 64'(1));
    chk($sformatf("g%0d_res_data", g), 64'(res_data), 64'(exp));
    chk($sformatf("g%0d_res_group", g), 64'(res_group), 64'(g));
    d0     = res_data;
    grp0   = res_group;
    stable = 1'b1;
    no_rd  = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!res_valid || res_data !== d0 || res_group !== grp0) stable = 1'b0;
      if (mem_rd_en) no_rd = 1'b0;
    end
    if (hold > 0) begin
      chk($sformatf("g%0d_hold_stable", g), 64'(stable), 64'(1));
      chk($sformatf("g%0d_hold_no_rd", g), 64'(no_rd), 64'(1));
    end
    if (drop_rdy) np_rd_en = 2'b00;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk($sformatf("g%0d_done", g), 64'(done), 64'(g == GROUPS - 1));
    chk($sformatf("g%0d_busy_after", g), 64'(busy), 64'(g != GROUPS - 1));
  endtask

  task automatic run_layer(input logic [1:0] b0, input logic [1:0] b1, input int hold, input int stall,
                           input bit dup, input bit stray, input logic [1:0] e0, input logic [1:0] e1,
                           input bit eerr);
    int          abase;
    int          dbase;
    int          idx;
    bit          no_rd;
    logic [15:0] ew;
    logic [15:0] ei;
    logic [15:0] et;
    abase = addr_log.size();
    dbase = done_cnt;
    if (stall > 0) np_rd_en = 2'b10;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on_start", 64'(busy), 64'(1));
    chk("err_cleared_on_start", 64'(err_dup), 64'(0));
    // Lane 0 not ready: no reads may go out; a start pulse meanwhile must be ignored.
    no_rd = 1'b1;
    for (int s = 0; s < stall; s++) begin
      if (mem_rd_en) no_rd = 1'b0;
      start = (s == 1);
      @(negedge clk);
    end
    start = 1'b0;
    if (stall > 0) chk("stall_no_rd", 64'(no_rd), 64'(1));
    np_rd_en = 2'b11;
    do_group(0, b0, dup, stray, hold, 1'b0, e0);
    do_group(1, b1, 1'b0, stray, hold, 1'b0, e1);
    @(negedge clk);
    chk("err_dup_end", 64'(err_dup), 64'(eerr));
    chk("done_count", 64'(done_cnt - dbase), 64'(1));
    chk("rd_count", 64'(addr_log.size() - abase), 64'(GROUPS * CHUNKS));
    for (int g = 0; g < GROUPS; g++) begin
      for (int c = 0; c < CHUNKS; c++) begin
        idx = abase + g * CHUNKS + c;
        ew  = 16'(g * CHUNKS + c);
        ei  = 16'(c);
        et  = 16'(g);
        if (idx < addr_log.size())
          chk($sformatf("addr_g%0d_c%0d", g, c), 64'(addr_log[idx]), 64'({ew, ei, et}));
      end
    end
  endtask

  typedef struct {
    logic [1:0] b0;
    logic [1:0] b1;
    int         hold;
    int         stall;
    bit         dup;
    bit         stray;
    logic [1:0] e0;
    logic [1:0] e1;
    bit         eerr;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [1:0] rb0;
    logic [1:0] rb1;

    tbl[0] = '{b0: 2'b11, b1: 2'b11, hold: 0,  stall: 0, dup: 1'b0, stray: 1'b0, e0: 2'b11, e1: 2'b01, eerr: 1'b0};
    tbl[1] = '{b0: 2'b01, b1: 2'b10, hold: 10, stall: 0, dup: 1'b0, stray: 1'b1, e0: 2'b01, e1: 2'b00, eerr: 1'b0};
    tbl[2] = '{b0: 2'b10, b1: 2'b01, hold: 2,  stall: 5, dup: 1'b1, stray: 1'b0, e0: 2'b10, e1: 2'b01, eerr: 1'b1};
    tbl[3] = '{b0: 2'b00, b1: 2'b11, hold: 1,  stall: 0, dup: 1'b0, stray: 1'b1, e0: 2'b00, e1: 2'b01, eerr: 1'b0};

    rst_n        = 1'b0;
    start        = 1'b0;
    np_rd_en     = 2'b11;
    np_out_valid = '0;
    np_out       = '0;
    res_ready    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'({busy, done, mem_rd_en, np_data_valid, res_valid, err_dup, res_data, res_group}), 64'(0));
    chk("reset_addr", 64'({w_addr, in_addr, thr_addr}), 64'(0));
    rst_n = 1'b1;

    for (int t = 0; t < 4; t++) begin
      run_layer(tbl[t].b0, tbl[t].b1, tbl[t].hold, tbl[t].stall, tbl[t].dup, tbl[t].stray,
                tbl[t].e0, tbl[t].e1, tbl[t].eerr);
    end

    // Reset while group 1 is waiting in ISSUE, with err_dup already set.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_group(0, 2'b11, 1'b1, 1'b0, 0, 1'b1, 2'b11);
    repeat (3) begin
      @(negedge clk);
      chk("issue_wait_no_rd", 64'({busy, mem_rd_en}), 64'(2'b10));
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", 64'({busy, done, mem_rd_en, np_data_valid, res_valid, err_dup, res_data, res_group}), 64'(0));
    chk("midrst_addr", 64'({w_addr, in_addr, thr_addr}), 64'(0));
    rst_n    = 1'b1;
    np_rd_en = 2'b11;
    run_layer(2'b01, 2'b01, 0, 0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rb0 = 2'($urandom);
      rb1 = 2'($urandom);
      run_layer(rb0, rb1, int'($urandom_range(0, 4)), 0, 1'b0, 1'($urandom),
                model_res(0, rb0), model_res(1, rb1), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
